// File: rtl/ifu_prefetch_pkg.sv
// Shared defines and types for the ifu_prefetch slice.
// Optional build macro IFU_PERF_EN (consumed by ifu_prefetch) adds fetch/discard counters.
`ifndef IFU_PREFETCH_DEFS
`define IFU_PREFETCH_DEFS
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NO_STOP
`define NO_STOP 1'b0
`endif
`ifndef REBOOT_ADDRESS
`define REBOOT_ADDRESS 32'h0000_1000
`endif
`define IFU_FIFO_DEPTH_DEF 4
`define IFU_MAX_OUTSTANDING_DEF 2
`endif

package ifu_prefetch_pkg;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } ifu_state_e;

    // Pointer width with one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with clear, registered storage and wrap-bit pointers.
// Head data is read straight from the storage registers (no write-to-read bypass).
module ifu_sync_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = ptr_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [PW-1:0]    count_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]    waddr, raddr;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (count_o == PW'(DEPTH));

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign waddr = IW'(wr_ptr_q % PW'(DEPTH));
    assign raddr = IW'(rd_ptr_q % PW'(DEPTH));

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_q;

        always_ff @(posedge clk_i or negedge n_rst_i) begin
            if (!n_rst_i) begin
                entry_q <= '0;
            end else if (do_push && !clear_i && waddr == IW'(gi)) begin
                entry_q <= data_i;
            end
        end

        assign mem[gi] = entry_q;
    end

    assign data_o = mem[raddr];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Pipelined instruction prefetcher: credit-limited req/gnt/rvalid fetch into an instruction buffer.
// Define IFU_PERF_EN to add saturating perf_fetched_o / perf_discarded_o counters.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     FIFO_DEPTH      = `IFU_FIFO_DEPTH_DEF,
    parameter int unsigned     MAX_OUTSTANDING = `IFU_MAX_OUTSTANDING_DEF,
    parameter logic [XLEN-1:0] RESET_PC        = `REBOOT_ADDRESS
) (
    input  logic            clk_i,
    input  logic            n_rst_i,
    input  logic [5:0]      stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] new_pc_i,
    input  logic            branch_redirect_i,
    input  logic [XLEN-1:0] branch_redirect_pc_i,
    input  logic [XLEN-1:0] bp_next_pc_i,
    input  logic            bp_taken_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic            next_taken_o,
    output logic            branch_slot_end_o,
    output logic            stall_req_o
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_discarded_o
`endif
);

    localparam int unsigned OW     = ptr_width(MAX_OUTSTANDING);
    localparam int unsigned FW     = ptr_width(FIFO_DEPTH);
    localparam int unsigned META_W = 2 * XLEN + 2;
    localparam int unsigned INST_W = XLEN + META_W;

    ifu_state_e      state_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            slot_pending_q, slot_pending_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [OW-1:0]   discard_q, discard_d;

    logic            started;
    logic            redirect_any;
    logic [XLEN-1:0] target_pc;
    logic            fire;
    logic            rsp_live;
    logic            rsp_drop;
    logic            deq;
    logic [31:0]     credit_used;

    logic [META_W-1:0] meta_wdata, meta_rdata;
    logic [INST_W-1:0] inst_wdata, inst_rdata;
    logic              meta_empty, meta_full, inst_empty, inst_full;
    logic [OW-1:0]     meta_count;
    logic [FW-1:0]     inst_count;

    assign started      = (state_q == ST_RUN);
    assign redirect_any = flush_i | branch_redirect_i;
    assign target_pc    = flush_i ? new_pc_i : branch_redirect_pc_i;

    // Credits cover both in-flight requests and buffered words, so the buffer can never overflow.
    assign credit_used = 32'(outst_q) + 32'(inst_count);
    assign imem_req_o  = started & ~redirect_any
                       & (32'(outst_q) < MAX_OUTSTANDING)
                       & (credit_used < FIFO_DEPTH);
    assign imem_addr_o = fetch_pc_q;

    assign fire     = imem_req_o & imem_gnt_i;
    assign rsp_live = imem_rvalid_i & (discard_q == '0) & ~redirect_any;
    assign rsp_drop = imem_rvalid_i & ~rsp_live;
    assign deq      = ~inst_empty & (stall_i[0] == `NO_STOP);

    assign meta_wdata = {fetch_pc_q, bp_next_pc_i, bp_taken_i, slot_pending_q};
    assign inst_wdata = {imem_rdata_i, meta_rdata};

    // Metadata only exists for live requests; stale responses are matched against discard_q instead.
    ifu_sync_fifo #(
        .WIDTH (META_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_meta_q (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .clear_i (redirect_any),
        .push_i  (fire),
        .data_i  (meta_wdata),
        .pop_i   (rsp_live),
        .data_o  (meta_rdata),
        .empty_o (meta_empty),
        .full_o  (meta_full),
        .count_o (meta_count)
    );

    ifu_sync_fifo #(
        .WIDTH (INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk_i   (clk_i),
        .n_rst_i (n_rst_i),
        .clear_i (redirect_any),
        .push_i  (rsp_live),
        .data_i  (inst_wdata),
        .pop_i   (deq),
        .data_o  (inst_rdata),
        .empty_o (inst_empty),
        .full_o  (inst_full),
        .count_o (inst_count)
    );

    assign inst_valid_o      = ~inst_empty;
    assign inst_o            = inst_rdata[INST_W-1 -: XLEN];
    assign pc_o              = inst_rdata[2*XLEN+1 -: XLEN];
    assign next_pc_o         = inst_rdata[XLEN+1 -: XLEN];
    assign next_taken_o      = inst_rdata[1];
    assign branch_slot_end_o = inst_rdata[0];
    assign stall_req_o       = inst_empty & started;

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        slot_pending_d = slot_pending_q;
        outst_d        = outst_q;
        discard_d      = discard_q;
        if (redirect_any) begin
            // Everything still in flight after this cycle belongs to the old stream.
            outst_d        = outst_q - OW'(imem_rvalid_i);
            discard_d      = outst_q - OW'(imem_rvalid_i);
            fetch_pc_d     = target_pc;
            slot_pending_d = ~flush_i;
        end else begin
            if (fire) begin
                fetch_pc_d     = bp_next_pc_i;
                slot_pending_d = 1'b0;
            end
            outst_d = outst_q + OW'(fire) - OW'(imem_rvalid_i);
            if (imem_rvalid_i && discard_q != '0) begin
                discard_d = discard_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q        <= ST_RESET;
            fetch_pc_q     <= RESET_PC;
            slot_pending_q <= 1'b0;
            outst_q        <= '0;
            discard_q      <= '0;
        end else begin
            case (state_q)
                ST_RESET: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
            fetch_pc_q     <= fetch_pc_d;
            slot_pending_q <= slot_pending_d;
            outst_q        <= outst_d;
            discard_q      <= discard_d;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched_q, perf_discarded_q;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else begin
            if (deq && perf_fetched_q != '1) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (rsp_drop && perf_discarded_q != '1) begin
                perf_discarded_q <= perf_discarded_q + 32'd1;
            end
        end
    end

    assign perf_fetched_o   = perf_fetched_q;
    assign perf_discarded_o = perf_discarded_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{stall_i[5:1], meta_empty, meta_full, meta_count, inst_full, rsp_drop};

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed startup table, corner-case sequences and
// a randomized phase scored against an instruction-stream model of the prefetcher.
`timescale 1ns/1ps
module tb_ifu_prefetch;

    localparam int unsigned MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_redirect_i;
    logic [31:0] branch_redirect_pc_i;
    logic [31:0] bp_next_pc_i;
    logic        bp_taken_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] next_pc_o;
    logic        next_taken_o;
    logic        branch_slot_end_o;
    logic        stall_req_o;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_discarded_o;
`endif

    always #5 clk_i = ~clk_i;

    ifu_prefetch #(
        .XLEN            (32),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk_i                (clk_i),
        .n_rst_i              (n_rst_i),
        .stall_i              (stall_i),
        .flush_i              (flush_i),
        .new_pc_i             (new_pc_i),
        .branch_redirect_i    (branch_redirect_i),
        .branch_redirect_pc_i (branch_redirect_pc_i),
        .bp_next_pc_i         (bp_next_pc_i),
        .bp_taken_i           (bp_taken_i),
        .imem_req_o           (imem_req_o),
        .imem_addr_o          (imem_addr_o),
        .imem_gnt_i           (imem_gnt_i),
        .imem_rvalid_i        (imem_rvalid_i),
        .imem_rdata_i         (imem_rdata_i),
        .inst_valid_o         (inst_valid_o),
        .inst_o               (inst_o),
        .pc_o                 (pc_o),
        .next_pc_o            (next_pc_o),
        .next_taken_o         (next_taken_o),
        .branch_slot_end_o    (branch_slot_end_o),
        .stall_req_o          (stall_req_o)
`ifdef IFU_PERF_EN
        ,
        .perf_fetched_o       (perf_fetched_o),
        .perf_discarded_o     (perf_discarded_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    typedef struct {
        logic        stall0;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_sreq;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          gnt_rand = 0;
    bit          taken_en = 0;
    int          tb_outst = 0;
    bit          started_m = 0;
    bit          last_rvalid = 0;
    int          last_due = -1;
    int          n_deq = 0;
    logic [31:0] exp_pc = RST_PC;
    logic        exp_slot = 1'b0;
    logic [31:0] prev_fire_addr = '0;
    bit          prev_fire_valid = 0;
    rsp_t        mem_q[$];
    vec_t        vec[9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [31:0] bp_pred(input logic [31:0] pc, input bit en);
        return (en && pc == 32'h10) ? 32'h40 : pc + 32'd4;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    // One clock cycle: drive memory/bp, observe, score, advance to the next negedge.
    task automatic cycle();
        logic fire;
        logic rv;
        int   due;
        rv = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rv = 1'b1;
            imem_rdata_i = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rdata_i = $urandom;
        end
        imem_rvalid_i = rv;
        imem_gnt_i    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bp_next_pc_i  = bp_pred(imem_addr_o, taken_en);
        bp_taken_i    = taken_en && (imem_addr_o == 32'h10);
        #1;
        last_rvalid = rv;
        fire = imem_req_o & imem_gnt_i;
        if (imem_req_o) check("req_credit", 128'(tb_outst < MAXO), 128'(1));
        if (flush_i || branch_redirect_i) check("req_in_flush", 128'(imem_req_o), 128'(0));
        check("stall_req", 128'(stall_req_o), 128'(!inst_valid_o && started_m));
        if (fire) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{imem_addr_o, due});
            if (prev_fire_valid && prev_fire_addr == 32'h10 && taken_en)
                check("taken_fetch_addr", 128'(imem_addr_o), 128'(32'h40));
            prev_fire_addr  = imem_addr_o;
            prev_fire_valid = 1;
        end
        if (inst_valid_o && !stall_i[0]) begin
            n_deq++;
            if (!(flush_i || branch_redirect_i)) begin
                check("head", {pc_o, inst_o, next_pc_o, next_taken_o, branch_slot_end_o},
                      {exp_pc, mem_word(exp_pc), bp_pred(exp_pc, taken_en),
                       taken_en && (exp_pc == 32'h10), exp_slot});
                exp_pc   = bp_pred(exp_pc, taken_en);
                exp_slot = 1'b0;
            end
        end
        if (flush_i) begin
            exp_pc = new_pc_i; exp_slot = 1'b0; prev_fire_valid = 0;
        end else if (branch_redirect_i) begin
            exp_pc = branch_redirect_pc_i; exp_slot = 1'b1; prev_fire_valid = 0;
        end
        tb_outst = tb_outst + int'(fire) - int'(rv);
        @(posedge clk_i);
        if (n_rst_i) started_m = 1;
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!inst_valid_o && k < 60) begin
            cycle();
            k++;
        end
        if (!inst_valid_o) timeout_fail(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef IFU_PERF_EN
        logic [31:0] disc_before;
`endif
        int k;
        vec[0] = '{1'b0, 1'b0, RST_PC,          1'b0, 32'h0,           1'b0};
        vec[1] = '{1'b0, 1'b1, RST_PC,          1'b0, 32'h0,           1'b1};
        vec[2] = '{1'b0, 1'b1, RST_PC + 32'd4,  1'b0, 32'h0,           1'b1};
        vec[3] = '{1'b0, 1'b1, RST_PC + 32'd8,  1'b1, RST_PC,          1'b0};
        vec[4] = '{1'b0, 1'b1, RST_PC + 32'd12, 1'b1, RST_PC + 32'd4,  1'b0};
        vec[5] = '{1'b0, 1'b1, RST_PC + 32'd16, 1'b1, RST_PC + 32'd8,  1'b0};
        vec[6] = '{1'b1, 1'b1, RST_PC + 32'd20, 1'b1, RST_PC + 32'd12, 1'b0};
        vec[7] = '{1'b1, 1'b1, RST_PC + 32'd24, 1'b1, RST_PC + 32'd12, 1'b0};
        vec[8] = '{1'b1, 1'b0, RST_PC + 32'd28, 1'b1, RST_PC + 32'd12, 1'b0};

        n_rst_i = 1'b0;
        stall_i = '0;
        flush_i = 1'b0;
        new_pc_i = '0;
        branch_redirect_i = 1'b0;
        branch_redirect_pc_i = '0;
        bp_next_pc_i = '0;
        bp_taken_i = 1'b0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;

        repeat (2) @(negedge clk_i);
        check("reset_bus", {imem_req_o, imem_addr_o, stall_req_o}, {1'b0, RST_PC, 1'b0});
        check("reset_head", {inst_valid_o, inst_o, pc_o, next_pc_o, next_taken_o, branch_slot_end_o}, '0);
`ifdef IFU_PERF_EN
        check("reset_perf", {perf_fetched_o, perf_discarded_o}, '0);
`endif
        n_rst_i = 1'b1;

        // Startup with gnt tied high and 1-cycle latency, then stall until the buffer is full.
        for (int i = 0; i < 9; i++) begin
            stall_i = {5'b0, vec[i].stall0};
            #1;
            check($sformatf("vec%0d", i),
                  {imem_req_o, imem_addr_o, inst_valid_o, (inst_valid_o ? pc_o : 32'h0), stall_req_o},
                  {vec[i].exp_req, vec[i].exp_addr, vec[i].exp_valid, vec[i].exp_pc, vec[i].exp_sreq});
            cycle();
        end
        repeat (7) cycle();
        check("stall_full_req", 128'(imem_req_o), 128'(0));
        check("stall_hold_head", {inst_valid_o, pc_o}, {1'b1, RST_PC + 32'd12});
        stall_i = '0;
        repeat (20) cycle();

        // Redirect with two late responses in flight, taken while decode is stalled.
        lat_min = 3;
        lat_max = 3;
        k = 0;
        while (tb_outst != 2 && k < 40) begin
            cycle();
            k++;
        end
        if (tb_outst != 2) timeout_fail("redir_outstanding");
`ifdef IFU_PERF_EN
        disc_before = perf_discarded_o;
`endif
        stall_i = 6'b000001;
        branch_redirect_i = 1'b1;
        branch_redirect_pc_i = 32'h0000_0100;
        cycle();
        branch_redirect_i = 1'b0;
        stall_i = '0;
        wait_valid("redir_first");
        check("redir_first", {pc_o, branch_slot_end_o}, {32'h100, 1'b1});
        cycle();
        wait_valid("redir_second");
        check("redir_second", {pc_o, branch_slot_end_o}, {32'h104, 1'b0});
        repeat (10) cycle();
`ifdef IFU_PERF_EN
        check("perf_discarded", 128'(perf_discarded_o - disc_before), 128'(2));
`endif

        // Flush in the same cycle a response returns.
        lat_min = 1;
        lat_max = 1;
        repeat (5) cycle();
        k = 0;
        while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && k < 40) begin
            cycle();
            k++;
        end
        flush_i = 1'b1;
        new_pc_i = 32'h0000_0200;
        cycle();
        flush_i = 1'b0;
        if (!last_rvalid) timeout_fail("flush_with_rvalid");
        wait_valid("flush_head");
        check("flush_head", {pc_o, branch_slot_end_o}, {32'h200, 1'b0});
        repeat (5) cycle();

        // Predicted-taken branch at 0x10.
        taken_en = 1;
        flush_i = 1'b1;
        new_pc_i = 32'h0000_0008;
        cycle();
        flush_i = 1'b0;
        k = 0;
        while (!(inst_valid_o && pc_o == 32'h10) && k < 60) begin
            cycle();
            k++;
        end
        if (!(inst_valid_o && pc_o == 32'h10)) timeout_fail("taken_head");
        check("taken_head", {next_taken_o, next_pc_o}, {1'b1, 32'h40});
        cycle();
        wait_valid("taken_follow");
        check("taken_follow", 128'(pc_o), 128'(32'h40));

        // Randomized traffic: random grant, latency, stalls, flushes and redirects.
        gnt_rand = 1;
        lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            stall_i = {5'($urandom), 1'($urandom_range(0, 9) < 3)};
            flush_i = ($urandom_range(0, 99) < 2);
            new_pc_i = 32'($urandom_range(0, 63)) << 2;
            branch_redirect_i = ($urandom_range(0, 99) < 3);
            branch_redirect_pc_i = 32'($urandom_range(0, 63)) << 2;
            cycle();
        end
        stall_i = '0;
        flush_i = 1'b0;
        branch_redirect_i = 1'b0;
        repeat (40) cycle();
`ifdef IFU_PERF_EN
        check("perf_fetched", 128'(perf_fetched_o), 128'(n_deq));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
